// File: rtl/q_channel_pkg.sv
// q_channel_pkg
// Shared Q-channel definitions: responder FSM state encoding, protocol
// signal levels, counter width and a saturating increment helper.
package q_channel_pkg;

  typedef enum logic [2:0] {
    Q_RUN      = 3'd0,
    Q_REQUEST  = 3'd1,
    Q_STOPPED  = 3'd2,
    Q_EXIT     = 3'd3,
    Q_DENIED   = 3'd4,
    Q_CONTINUE = 3'd5
  } q_state_e;

  // Protocol levels on the Q-channel wires
  localparam logic QREQN_REQUEST  = 1'b0;
  localparam logic QREQN_RELEASE  = 1'b1;
  localparam logic QACCEPTN_GRANT = 1'b0;
  localparam logic QACCEPTN_IDLE  = 1'b1;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counters stick at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/q_device_responder_if.sv
// q_device_responder_if
// Groups the Q-channel handshake and the device-side control wires.
//   master : controller/device-side driver (drives qreqn, busy, wake)
//   slave  : responder view (drives accept/deny/active and device controls)
interface q_device_responder_if;
  logic qreqn;
  logic busy;
  logic wake;
  logic qacceptn;
  logic qdeny;
  logic qactive;
  logic quiesce;
  logic clk_en;
  logic protocol_err;

  modport master (
    output qreqn, busy, wake,
    input  qacceptn, qdeny, qactive, quiesce, clk_en, protocol_err
  );

  modport slave (
    input  qreqn, busy, wake,
    output qacceptn, qdeny, qactive, quiesce, clk_en, protocol_err
  );
endinterface

// File: rtl/q_sync.sv
// q_sync
// Multi-flop synchronizer for a single asynchronous bit.
//   clock, reset : clock, async active-high reset (flops load RESET_VAL)
//   data_i       : asynchronous input
//   data_o       : synchronized output (last flop of the chain)
module q_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic data_i,
  output logic data_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], data_i};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= {STAGES{RESET_VAL}};
    else       sync_q <= sync_d;
  end

  assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/q_device_responder.sv
// q_device_responder
// Device-side Q-channel responder. Decides whether to accept or deny a
// quiescence request based on device idleness and wake demand, and drives
// the device quiesce / clock-gate controls. Every output is a flop.
//   clock, reset     : clock, async active-high reset
//   qreqn_i          : async quiescence request (active-low)
//   device_busy_i    : device has outstanding work
//   wake_req_i       : device needs to run
//   qacceptn_o       : accept (active-low)
//   qdeny_o          : deny
//   qactive_o        : registered busy|wake
//   quiesce_o        : stop taking new work
//   device_clk_en_o  : device clock gate enable
//   protocol_err_o   : one-cycle pulse on qreqn release while requesting
//
// state      | meaning
// Q_RUN      | normal operation, no request pending
// Q_REQUEST  | request seen, counting idle cycles / timeout
// Q_STOPPED  | request accepted, device clock gated
// Q_EXIT     | request released after accept, one cycle
// Q_DENIED   | request denied, waiting for release
// Q_CONTINUE | request released after deny, one cycle
module q_device_responder
  import q_channel_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_CYCLES  = 4,
  parameter int unsigned DENY_TIMEOUT = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic qreqn_i,
  input  logic device_busy_i,
  input  logic wake_req_i,
  output logic qacceptn_o,
  output logic qdeny_o,
  output logic qactive_o,
  output logic quiesce_o,
  output logic device_clk_en_o,
  output logic protocol_err_o
);

  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] DENY_LIM = CNT_W'(DENY_TIMEOUT);

  logic qreqn_s;

  q_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (QREQN_RELEASE)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .data_i (qreqn_i),
    .data_o (qreqn_s)
  );

  q_state_e         state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] idle_next, tmo_next;
  logic qacceptn_q, qacceptn_d;
  logic qdeny_q, qdeny_d;
  logic qactive_q, qactive_d;
  logic quiesce_q, quiesce_d;
  logic clk_en_q, clk_en_d;
  logic perr_q, perr_d;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    tmo_cnt_d  = '0;
    perr_d     = 1'b0;

    // Compare against the post-increment value so the decision lands on
    // the same edge the count would reach its limit.
    idle_next = device_busy_i ? '0 : sat_inc(idle_cnt_q);
    tmo_next  = sat_inc(tmo_cnt_q);

    case (state_q)
      Q_RUN: begin
        if (qreqn_s == QREQN_REQUEST) state_d = Q_REQUEST;
      end
      Q_REQUEST: begin
        if (qreqn_s == QREQN_RELEASE) begin
          perr_d  = 1'b1;
          state_d = Q_RUN;
        end else if (wake_req_i) begin
          state_d = Q_DENIED;
        end else if (idle_next == IDLE_LIM) begin
          state_d = Q_STOPPED;
        end else if (tmo_next == DENY_LIM) begin
          state_d = Q_DENIED;
        end else begin
          // Counters only advance while staying here, so they read zero
          // on every fresh entry.
          idle_cnt_d = idle_next;
          tmo_cnt_d  = tmo_next;
        end
      end
      Q_STOPPED: begin
        if (qreqn_s == QREQN_RELEASE) state_d = Q_EXIT;
      end
      Q_EXIT:     state_d = Q_RUN;
      Q_DENIED: begin
        if (qreqn_s == QREQN_RELEASE) state_d = Q_CONTINUE;
      end
      Q_CONTINUE: state_d = Q_RUN;
      default:    state_d = Q_RUN;
    endcase

    // Outputs decoded from the next state so they change with the state flop.
    qacceptn_d = ((state_d == Q_STOPPED) || (state_d == Q_EXIT)) ?
                 QACCEPTN_GRANT : QACCEPTN_IDLE;
    qdeny_d    = (state_d == Q_DENIED) || (state_d == Q_CONTINUE);
    quiesce_d  = (state_d == Q_REQUEST) || (state_d == Q_STOPPED);
    clk_en_d   = (state_d != Q_STOPPED);
    qactive_d  = device_busy_i | wake_req_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= Q_RUN;
      idle_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      qacceptn_q <= QACCEPTN_IDLE;
      qdeny_q    <= 1'b0;
      qactive_q  <= 1'b0;
      quiesce_q  <= 1'b0;
      clk_en_q   <= 1'b1;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      qacceptn_q <= qacceptn_d;
      qdeny_q    <= qdeny_d;
      qactive_q  <= qactive_d;
      quiesce_q  <= quiesce_d;
      clk_en_q   <= clk_en_d;
      perr_q     <= perr_d;
    end
  end

  assign qacceptn_o      = qacceptn_q;
  assign qdeny_o         = qdeny_q;
  assign qactive_o       = qactive_q;
  assign quiesce_o       = quiesce_q;
  assign device_clk_en_o = clk_en_q;
  assign protocol_err_o  = perr_q;

endmodule

// File: tb/tb_q_device_responder.sv
module tb_q_device_responder;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  q_device_responder_if qif ();

  q_device_responder #(
    .SYNC_STAGES  (2),
    .IDLE_CYCLES  (4),
    .DENY_TIMEOUT (32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .qreqn_i         (qif.qreqn),
    .device_busy_i   (qif.busy),
    .wake_req_i      (qif.wake),
    .qacceptn_o      (qif.qacceptn),
    .qdeny_o         (qif.qdeny),
    .qactive_o       (qif.qactive),
    .quiesce_o       (qif.quiesce),
    .device_clk_en_o (qif.clk_en),
    .protocol_err_o  (qif.protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic q, b, w;
    logic acc, deny, act, qui, clk, perr;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic q, b, w, acc, deny, act, qui, clk, perr);
    vec_t v;
    v.q = q; v.b = b; v.w = w;
    v.acc = acc; v.deny = deny; v.act = act; v.qui = qui; v.clk = clk; v.perr = perr;
    return v;
  endfunction

  task automatic drive(input logic q, input logic b, input logic w);
    qif.qreqn = q;
    qif.busy  = b;
    qif.wake  = w;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic acc, deny, act, qui, clk, perr);
    chk({nm, "_acceptn"}, qif.qacceptn, acc);
    chk({nm, "_deny"}, qif.qdeny, deny);
    chk({nm, "_active"}, qif.qactive, act);
    chk({nm, "_quiesce"}, qif.quiesce, qui);
    chk({nm, "_clk_en"}, qif.clk_en, clk);
    chk({nm, "_perr"}, qif.protocol_err, perr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //                q  b  w  acc deny act qui clk perr
    vecs[0]  = mk(H, H, L, H, L, H, L, H, L);  // RUN, active follows busy
    vecs[1]  = mk(L, L, L, H, L, L, L, H, L);  // qreqn fall, sync stage 1
    vecs[2]  = mk(L, L, L, H, L, L, L, H, L);  // sync stage 2
    vecs[3]  = mk(L, L, L, H, L, L, H, H, L);  // edge 3: Q_REQUEST
    vecs[4]  = mk(L, L, L, H, L, L, H, H, L);  // idle 1
    vecs[5]  = mk(L, L, L, H, L, L, H, H, L);  // idle 2
    vecs[6]  = mk(L, L, L, H, L, L, H, H, L);  // idle 3
    vecs[7]  = mk(L, L, L, L, L, L, H, L, L);  // idle 4: Q_STOPPED
    vecs[8]  = mk(L, L, H, L, L, H, H, L, L);  // wake while stopped
    vecs[9]  = mk(H, L, L, L, L, L, H, L, L);  // qreqn rise, sync 1
    vecs[10] = mk(H, L, L, L, L, L, H, L, L);  // sync 2
    vecs[11] = mk(H, L, L, L, L, L, L, H, L);  // Q_EXIT
    vecs[12] = mk(H, L, L, H, L, L, L, H, L);  // Q_RUN, 4 edges after rise
    vecs[13] = mk(H, L, H, H, L, H, L, H, L);  // RUN, active follows wake

    reset = 1'b1;
    drive(H, L, L);
    #1;
    chk_all("reset", H, L, L, L, H, L);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tick(1);
    chk_all("post_reset", H, L, L, L, H, L);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].q, vecs[i].b, vecs[i].w);
      tick(1);
      chk_all($sformatf("vec%0d", i), vecs[i].acc, vecs[i].deny, vecs[i].act,
              vecs[i].qui, vecs[i].clk, vecs[i].perr);
    end

    // Busy timeout -> deny after 32 cycles in Q_REQUEST
    drive(L, H, L);
    tick(3);
    chk("tmo_entry_quiesce", qif.quiesce, H);
    tick(31);
    chk("tmo_31_deny", qif.qdeny, L);
    chk("tmo_31_quiesce", qif.quiesce, H);
    tick(1);
    chk("tmo_32_deny", qif.qdeny, H);
    chk("tmo_32_quiesce", qif.quiesce, L);
    chk("tmo_32_acceptn", qif.qacceptn, H);
    drive(H, L, L);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("tmo_rel%0d_deny", i), qif.qdeny, H);
      chk($sformatf("tmo_rel%0d_acceptn", i), qif.qacceptn, H);
    end
    tick(1);
    chk("tmo_rel4_deny", qif.qdeny, L);
    chk("tmo_rel4_acceptn", qif.qacceptn, H);

    // Idle-count restart on a busy pulse at idle count 3
    drive(L, L, L);
    tick(3);
    chk("rst_cnt_entry", qif.quiesce, H);
    tick(3);
    chk("rst_cnt_idle3", qif.qacceptn, H);
    drive(L, H, L);
    tick(1);
    chk("rst_cnt_pulse", qif.qacceptn, H);
    drive(L, L, L);
    tick(3);
    chk("rst_cnt_idle3b", qif.qacceptn, H);
    tick(1);
    chk("rst_cnt_accept", qif.qacceptn, L);
    chk("rst_cnt_clk_en", qif.clk_en, L);
    drive(H, L, L);
    tick(3);
    chk("rst_cnt_exit", qif.qacceptn, L);
    tick(1);
    chk("rst_cnt_run", qif.qacceptn, H);

    // Wake coinciding with idle count reaching 4 -> deny wins
    drive(L, L, L);
    tick(6);
    drive(L, L, H);
    tick(1);
    chk("wake_coinc_deny", qif.qdeny, H);
    chk("wake_coinc_acceptn", qif.qacceptn, H);
    chk("wake_coinc_clk_en", qif.clk_en, H);
    drive(H, L, L);
    tick(4);
    chk("wake_coinc_release", qif.qdeny, L);

    // Protocol error: qreqn released while in Q_REQUEST
    drive(L, H, L);
    tick(3);
    chk("perr_entry", qif.quiesce, H);
    tick(1);
    drive(H, H, L);
    tick(2);
    chk("perr_pre_pulse", qif.protocol_err, L);
    chk("perr_pre_quiesce", qif.quiesce, H);
    tick(1);
    chk("perr_pulse", qif.protocol_err, H);
    chk("perr_run_quiesce", qif.quiesce, L);
    tick(1);
    chk("perr_pulse_end", qif.protocol_err, L);

    // Async reset while stopped
    drive(L, L, L);
    tick(7);
    chk("rst_stop_acceptn", qif.qacceptn, L);
    chk("rst_stop_clk_en", qif.clk_en, L);
    drive(L, L, H);
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst_async", H, L, L, L, H, L);
    tick(2);
    chk_all("rst_held", H, L, L, L, H, L);
    drive(H, L, L);
    reset = 1'b0;
    tick(1);
    chk_all("rst_release", H, L, L, L, H, L);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
